// File: rtl/fp_pkg.sv
// fp_pkg: shared fp32 field widths, integer limits, unpacked operand type and converter states
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN = 32'h80000000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: combinational unpack of an fp32 word into fields and class flags
module fp32_classify
  import fp_pkg::*;
(
  input  logic [31:0]     a,
  output logic            sign,
  output logic [EXP_W-1:0] exp,
  output logic [FRAC_W:0] man,
  output logic            is_zero,
  output logic            is_denorm,
  output logic            is_inf,
  output logic            is_nan
);
  fp32_t f;
  assign f = a;
  assign sign = f.sign;
  assign exp = f.exp;
  assign man = {|f.exp, f.frac};
  assign is_zero = ~|f.exp & ~|f.frac;
  assign is_denorm = ~|f.exp & |f.frac;
  assign is_inf = &f.exp & ~|f.frac;
  assign is_nan = &f.exp & |f.frac;
endmodule

// File: rtl/fp32_to_int32.sv
// fp32_to_int32: iterative fp32 to int32 converter, one mantissa bit shifted per cycle
module fp32_to_int32
  import fp_pkg::*;
#(
  parameter bit RNE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        overflow,
  output logic        invalid,
  output logic        inexact
);
  localparam logic [7:0] E_HALF = 8'(BIAS - 1);
  localparam logic [7:0] E_INT = 8'(BIAS + FRAC_W);
  localparam logic [7:0] E_MAX = 8'(BIAS + 31);
  logic sg, iz, idn, iinf, inan;
  logic [7:0] ex;
  logic [23:0] mn;
  fp32_classify u_cls (
    .a(a), .sign(sg), .exp(ex), .man(mn),
    .is_zero(iz), .is_denorm(idn), .is_inf(iinf), .is_nan(inan)
  );
  state_t st;
  logic s, dir, guard, sticky, ovf_r;
  logic [31:0] mag, rnd;
  logic [4:0] cnt;
  assign rnd = mag + {31'b0, RNE_EN && guard && (sticky || mag[0])};
  assign ovf_r = s ? rnd > INT32_MIN : rnd[31];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      res <= '0;
      overflow <= 1'b0;
      invalid <= 1'b0;
      inexact <= 1'b0;
      s <= 1'b0;
      dir <= 1'b0;
      guard <= 1'b0;
      sticky <= 1'b0;
      mag <= '0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          s <= sg;
          mag <= {8'b0, mn};
          guard <= 1'b0;
          sticky <= 1'b0;
          if (iinf || inan) begin
            st <= DONE;
            out_valid <= 1'b1;
            invalid <= 1'b1;
            res <= (inan || !sg) ? INT32_MAX : INT32_MIN;
          end else if (idn || ex <= E_HALF - 8'd1) begin
            st <= DONE;
            out_valid <= 1'b1;
            res <= '0;
            inexact <= ~iz;
          end else if (ex > E_MAX) begin
            st <= DONE;
            out_valid <= 1'b1;
            overflow <= 1'b1;
            res <= sg ? INT32_MIN : INT32_MAX;
          end else if (ex < E_INT) begin
            dir <= 1'b1;
            cnt <= 5'(E_INT - ex);
            st <= SHIFT;
          end else begin
            dir <= 1'b0;
            cnt <= 5'(ex - E_INT);
            st <= ex == E_INT ? ROUND : SHIFT;
          end
        end
        SHIFT: begin
          mag <= dir ? mag >> 1 : mag << 1;
          if (dir) begin
            sticky <= sticky | guard;
            guard <= mag[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) st <= ROUND;
        end
        ROUND: begin
          st <= DONE;
          out_valid <= 1'b1;
          overflow <= ovf_r;
          inexact <= (guard | sticky) & ~ovf_r;
          res <= ovf_r ? (s ? INT32_MIN : INT32_MAX) : (s ? ~rnd + 32'd1 : rnd);
        end
        DONE: if (out_ready) begin
          st <= IDLE;
          out_valid <= 1'b0;
          overflow <= 1'b0;
          invalid <= 1'b0;
          inexact <= 1'b0;
          in_ready <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_to_int32.sv
// tb_fp32_to_int32: scoreboard bench for the RNE and truncating converter variants
module tb_fp32_to_int32;
  typedef struct {
    logic [31:0] a;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic [1:0] iv = '0, ir, ov, orr = 2'b11, ovf, inv, inx;
  logic [31:0] av[2];
  logic [31:0] rs[2];

  fp32_to_int32 #(.RNE_EN(1)) u_rne (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .res(rs[0]),
    .overflow(ovf[0]), .invalid(inv[0]), .inexact(inx[0])
  );
  fp32_to_int32 #(.RNE_EN(0)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .res(rs[1]),
    .overflow(ovf[1]), .invalid(inv[1]), .inexact(inx[1])
  );

  exp_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit seen0 = 0, seen1 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic score(int k, exp_t e);
    chk($sformatf("res[%0d] a=%h", k, e.a), rs[k], e.r);
    chk($sformatf("flags{ovf,inv,inx}[%0d] a=%h", k, e.a), {29'b0, ovf[k], inv[k], inx[k]}, {29'b0, e.f});
    chk($sformatf("latency[%0d] a=%h", k, e.a), cyc - e.acc + 1, e.lat);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && ov[0] && !seen0) begin
      seen0 = 1;
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected output[0]: got %h want none", rs[0]);
      end else score(0, q0.pop_front());
    end
    if (!ov[0]) seen0 = 0;
  end

  always @(posedge clk) begin
    #1;
    if (!rst && ov[1] && !seen1) begin
      seen1 = 1;
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected output[1]: got %h want none", rs[1]);
      end else score(1, q1.pop_front());
    end
    if (!ov[1]) seen1 = 0;
  end

  task automatic send(int k, logic [31:0] op, logic [31:0] r, logic [2:0] f, int lat);
    exp_t e;
    int t = 0;
    while (!ir[k] && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!ir[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready timeout[%0d]: got 0 want 1", k);
      return;
    end
    e.a = op; e.r = r; e.f = f; e.lat = lat; e.acc = cyc + 1;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    av[k] = op;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || ir != 2'b11) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain timeout: got %0d pending want 0", q0.size() + q1.size());
    end
  endtask

  initial begin
    av[0] = '0;
    av[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {30'b0, ir}, 32'd3);
    chk("reset out_valid", {30'b0, ov}, 32'd0);
    chk("reset res", rs[0], 32'd0);
    rst = 0;
    @(posedge clk); #1;

    send(0, 32'h3F800000, 32'h00000001, 3'b000, 25);
    send(0, 32'h40200000, 32'h00000002, 3'b001, 24);
    send(0, 32'h40600000, 32'h00000004, 3'b001, 24);
    send(0, 32'hC0200000, 32'hFFFFFFFE, 3'b001, 24);
    send(0, 32'h4F000000, 32'h7FFFFFFF, 3'b100, 10);
    send(0, 32'hCF000000, 32'h80000000, 3'b000, 10);
    send(0, 32'h7FC00000, 32'h7FFFFFFF, 3'b010, 1);
    send(0, 32'hFF800000, 32'h80000000, 3'b010, 1);
    send(0, 32'h7F800000, 32'h7FFFFFFF, 3'b010, 1);
    send(0, 32'h00000001, 32'h00000000, 3'b001, 1);
    send(0, 32'h3F000000, 32'h00000000, 3'b001, 26);
    send(0, 32'hBF000000, 32'h00000000, 3'b001, 26);
    send(0, 32'h80000000, 32'h00000000, 3'b000, 1);
    send(0, 32'h3FC00000, 32'h00000002, 3'b001, 25);
    send(0, 32'hBFE00000, 32'hFFFFFFFE, 3'b001, 25);
    send(0, 32'h42C80000, 32'h00000064, 3'b000, 19);
    send(0, 32'h4B000000, 32'h00800000, 3'b000, 2);
    send(0, 32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 9);
    send(0, 32'hCF000001, 32'h80000000, 3'b100, 10);
    send(0, 32'h5F000000, 32'h7FFFFFFF, 3'b100, 1);
    send(0, 32'hDF000000, 32'h80000000, 3'b100, 1);
    send(0, 32'h3E800000, 32'h00000000, 3'b001, 1);
    send(0, 32'hBECCCCCD, 32'h00000000, 3'b001, 1);
    send(1, 32'h40600000, 32'h00000003, 3'b001, 24);
    send(1, 32'hC0200000, 32'hFFFFFFFE, 3'b001, 24);
    send(1, 32'h3F000000, 32'h00000000, 3'b001, 26);
    send(1, 32'h3FE00000, 32'h00000001, 3'b001, 25);
    send(1, 32'h4F000000, 32'h7FFFFFFF, 3'b100, 10);
    drain();

    orr[0] = 1'b0;
    send(0, 32'h40200000, 32'h00000002, 3'b001, 24);
    for (int t = 0; t < 60 && !ov[0]; t++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", {31'b0, ov[0]}, 32'd1);
      chk("hold res", rs[0], 32'd2);
      chk("hold flags", {29'b0, ovf[0], inv[0], inx[0]}, 32'd1);
      chk("hold in_ready", {31'b0, ir[0]}, 32'd0);
    end
    orr[0] = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", {31'b0, ov[0]}, 32'd0);
    chk("release in_ready", {31'b0, ir[0]}, 32'd1);
    chk("release flags", {29'b0, ovf[0], inv[0], inx[0]}, 32'd0);
    drain();

    av[0] = 32'h3F800000;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("rst in_ready", {31'b0, ir[0]}, 32'd1);
    chk("rst out_valid", {31'b0, ov[0]}, 32'd0);
    chk("rst res", rs[0], 32'd0);
    chk("rst flags", {29'b0, ovf[0], inv[0], inx[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    send(0, 32'h42C80000, 32'h00000064, 3'b000, 19);
    send(0, 32'hC0600000, 32'hFFFFFFFC, 3'b001, 24);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
